// File: rtl/canny_sched_if.sv
// Signal bundle between the Canny sequencer and the edge-detection datapath.
// The master side is the sequencer. The slave side is the datapath and frame source.
interface canny_sched_if;
    logic       load_end;
    logic       stall;
    logic       wr_en;
    logic [4:0] wr_row;
    logic [1:0] wr_grp;
    logic [1:0] pass_id;
    logic       win_en;
    logic [4:0] win_row;
    logic [4:0] win_col;
    logic       buf_swap;
    logic       readable;
    logic       done;

    modport master (
        input  load_end, stall,
        output wr_en, wr_row, wr_grp, pass_id, win_en, win_row, win_col,
               buf_swap, readable, done
    );

    modport slave (
        output load_end, stall,
        input  wr_en, wr_row, wr_grp, pass_id, win_en, win_row, win_col,
               buf_swap, readable, done
    );
endinterface

// File: rtl/canny_sched_ctrl.sv
// Top-level sequencer for the edge-detection datapath.
// It tracks the frame load, then walks four 3x3 window passes over the image
// interior. A ping-pong buffer swap separates each pass from the next.
module canny_sched_ctrl #(
    parameter int IMG_W     = 20,
    parameter int IMG_H     = 20,
    parameter int N_PASS    = 4,
    parameter int STAGE_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    canny_sched_if.master bus
);
    localparam int GRPS  = IMG_W / 5;
    localparam int N_GRP = GRPS * IMG_H;

    typedef enum logic [2:0] {
        S_LOAD,
        S_PASS,
        S_DRAIN,
        S_SWAP,
        S_DONE
    } state_t;

    state_t               state_reg;
    logic                 wr_en_reg;
    logic [6:0]           load_cnt_reg;
    logic [4:0]           wr_row_reg;
    logic [1:0]           wr_grp_reg;
    logic [1:0]           pass_reg;
    logic [4:0]           row_reg;
    logic [4:0]           col_reg;
    logic [2:0]           drain_reg;
    logic [STAGE_LAT-1:0] rd_pipe_reg;
    logic                 issue;

    // Stall takes effect in the cycle it is asserted.
    // A window is therefore issued only while PASS is active and stall is low.
    assign issue = (state_reg == S_PASS) && !bus.stall;

    // Main sequencer: load tracking, window walk, drain countdown, swap and done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_LOAD;
            wr_en_reg    <= 1'b0;
            load_cnt_reg <= '0;
            wr_row_reg   <= '0;
            wr_grp_reg   <= '0;
            pass_reg     <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            drain_reg    <= '0;
        end else begin
            case (state_reg)
                S_LOAD: begin
                    if (!wr_en_reg) begin
                        // First cycle after reset: present group 0.
                        wr_en_reg <= 1'b1;
                    end else if (bus.load_end || load_cnt_reg == 7'(N_GRP - 1)) begin
                        // The group shown in this cycle is the last one written.
                        wr_en_reg <= 1'b0;
                        state_reg <= S_PASS;
                        row_reg   <= 5'd1;
                        col_reg   <= 5'd1;
                    end else begin
                        load_cnt_reg <= load_cnt_reg + 7'd1;
                        if (wr_grp_reg == 2'(GRPS - 1)) begin
                            wr_grp_reg <= '0;
                            wr_row_reg <= wr_row_reg + 5'd1;
                        end else begin
                            wr_grp_reg <= wr_grp_reg + 2'd1;
                        end
                    end
                end
                S_PASS: begin
                    if (!bus.stall) begin
                        if (col_reg == 5'(IMG_W - 2)) begin
                            col_reg <= 5'd1;
                            if (row_reg == 5'(IMG_H - 2)) begin
                                state_reg <= S_DRAIN;
                                drain_reg <= '0;
                            end else begin
                                row_reg <= row_reg + 5'd1;
                            end
                        end else begin
                            col_reg <= col_reg + 5'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Let the last window flush through the stage pipeline before the swap.
                    if (drain_reg == 3'(STAGE_LAT - 1)) begin
                        state_reg <= S_SWAP;
                    end else begin
                        drain_reg <= drain_reg + 3'd1;
                    end
                end
                S_SWAP: begin
                    if (pass_reg == 2'(N_PASS - 1)) begin
                        state_reg <= S_DONE;
                    end else begin
                        pass_reg  <= pass_reg + 2'd1;
                        row_reg   <= 5'd1;
                        col_reg   <= 5'd1;
                        state_reg <= S_PASS;
                    end
                end
                S_DONE: begin
                    state_reg <= S_DONE;
                end
                default: begin
                    state_reg <= S_LOAD;
                end
            endcase
        end
    end

    // Delay line from window issue to the final-pass result.
    // It always shifts, so a stall bubble shows up as a gap in readable.
    genvar gi;
    generate
        for (gi = 0; gi < STAGE_LAT; gi = gi + 1) begin : g_rd_pipe
            if (gi == 0) begin : g_head
                // Stage 0 captures issues made in the final pass.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) rd_pipe_reg[0] <= 1'b0;
                    else        rd_pipe_reg[0] <= issue && (pass_reg == 2'(N_PASS - 1));
                end
            end else begin : g_tail
                // Later stages forward the previous stage.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) rd_pipe_reg[gi] <= 1'b0;
                    else        rd_pipe_reg[gi] <= rd_pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    assign bus.wr_en    = wr_en_reg;
    assign bus.wr_row   = wr_row_reg;
    assign bus.wr_grp   = wr_grp_reg;
    assign bus.pass_id  = pass_reg;
    assign bus.win_en   = issue;
    assign bus.win_row  = row_reg;
    assign bus.win_col  = col_reg;
    assign bus.buf_swap = (state_reg == S_SWAP);
    assign bus.done     = (state_reg == S_DONE);
    assign bus.readable = rd_pipe_reg[STAGE_LAT-1];
endmodule

// File: tb/tb_canny_sched_ctrl.sv
// Directed scoreboard bench for canny_sched_ctrl.
// It covers the full frame, a stalled pass, a mid-frame reset and an early load_end.
module tb_canny_sched_ctrl;
    typedef struct {
        int cyc;
        int a;
        int b;
        int c;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    canny_sched_if bus_if ();

    canny_sched_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    exp_t q_wr[$];
    exp_t q_win[$];
    int   q_rd[$];
    int   q_swap[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int done_cyc;
    int n_rd;

    logic       s_wr_en, s_win_en, s_buf_swap, s_readable, s_done;
    logic [4:0] s_wr_row, s_win_row, s_win_col;
    logic [1:0] s_wr_grp, s_pass_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Sample at mid-cycle and pop matching scoreboard entries.
    // Then advance to just after the next rising edge.
    task automatic step();
        exp_t e;
        int   t;
        @(negedge clk);
        s_wr_en    = bus_if.wr_en;
        s_wr_row   = bus_if.wr_row;
        s_wr_grp   = bus_if.wr_grp;
        s_pass_id  = bus_if.pass_id;
        s_win_en   = bus_if.win_en;
        s_win_row  = bus_if.win_row;
        s_win_col  = bus_if.win_col;
        s_buf_swap = bus_if.buf_swap;
        s_readable = bus_if.readable;
        s_done     = bus_if.done;

        if (q_wr.size() == 0) check("wr_en_idle", 32'(s_wr_en), 0);
        else if (s_wr_en) begin
            e = q_wr.pop_front();
            check("wr_cyc", cyc, e.cyc);
            check("wr_row", 32'(s_wr_row), e.b);
            check("wr_grp", 32'(s_wr_grp), e.c);
        end

        if (q_win.size() == 0) check("win_en_idle", 32'(s_win_en), 0);
        else if (s_win_en) begin
            e = q_win.pop_front();
            check("win_cyc", cyc, e.cyc);
            check("win_pass", 32'(s_pass_id), e.a);
            check("win_row", 32'(s_win_row), e.b);
            check("win_col", 32'(s_win_col), e.c);
        end

        if (s_readable) n_rd++;
        if (q_rd.size() == 0) check("readable_idle", 32'(s_readable), 0);
        else if (s_readable) begin
            t = q_rd.pop_front();
            check("readable_cyc", cyc, t);
        end

        if (q_swap.size() == 0) check("swap_idle", 32'(s_buf_swap), 0);
        else if (s_buf_swap) begin
            t = q_swap.pop_front();
            check("swap_cyc", cyc, t);
        end

        if (s_done && done_cyc < 0) done_cyc = cyc;
        $display("cyc %0d wr %0b %0d/%0d win %0b p%0d (%0d,%0d) swap %0b rd %0b done %0b",
                 cyc, s_wr_en, s_wr_row, s_wr_grp, s_win_en, s_pass_id, s_win_row, s_win_col,
                 s_buf_swap, s_readable, s_done);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        exp_t e;
        reset             = 1'b0;
        bus_if.load_end   = 1'b1;
        bus_if.stall      = 1'b0;
        cyc               = -10;
        done_cyc          = -1;
        n_rd              = 0;

        // ---- Reset state: every output is low while reset is held ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(bus_if.wr_en), 0);
        check("rst_win_en", 32'(bus_if.win_en), 0);
        check("rst_pass_id", 32'(bus_if.pass_id), 0);
        check("rst_buf_swap", 32'(bus_if.buf_swap), 0);
        check("rst_readable", 32'(bus_if.readable), 0);
        check("rst_done", 32'(bus_if.done), 0);
        @(posedge clk);
        #1;
        reset           = 1'b1;
        bus_if.load_end = 1'b0;
        cyc             = -1;

        // ---- Full frame: 80 groups, four unstalled passes, done ----
        for (int k = 0; k < 80; k++) begin
            e = '{cyc: k, a: 0, b: k / 4, c: k % 4};
            q_wr.push_back(e);
        end
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 324; i++) begin
                e = '{cyc: 80 + 327 * p + i, a: p, b: 1 + i / 18, c: 1 + i % 18};
                q_win.push_back(e);
            end
            q_swap.push_back(80 + 327 * p + 326);
        end
        for (int i = 0; i < 324; i++) q_rd.push_back(1063 + i);

        while (cyc < 1392) begin
            bus_if.load_end = (cyc == 79) || (cyc >= 1389);
            bus_if.stall    = (cyc >= 1389);
            step();
        end
        check("done_cycle", done_cyc, 1388);
        check("readable_total", n_rd, 324);
        check("done_held", 32'(s_done), 1);
        check("q_wr_empty", q_wr.size(), 0);
        check("q_win_empty", q_win.size(), 0);
        check("q_rd_empty", q_rd.size(), 0);
        check("q_swap_empty", q_swap.size(), 0);

        // ---- Second frame: counter-terminated load, stall in pass 1, reset in pass 2 ----
        bus_if.load_end = 1'b0;
        bus_if.stall    = 1'b0;
        reset           = 1'b0;
        @(negedge clk);
        check("rst2_done", 32'(bus_if.done), 0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        cyc      = -1;
        done_cyc = -1;
        n_rd     = 0;

        for (int k = 0; k < 80; k++) begin
            e = '{cyc: k, a: 0, b: k / 4, c: k % 4};
            q_wr.push_back(e);
        end
        for (int i = 0; i < 324; i++) begin
            e = '{cyc: 80 + i, a: 0, b: 1 + i / 18, c: 1 + i % 18};
            q_win.push_back(e);
        end
        for (int i = 0; i < 324; i++) begin
            e = '{cyc: 407 + i + ((i >= 111) ? 5 : 0), a: 1, b: 1 + i / 18, c: 1 + i % 18};
            q_win.push_back(e);
        end
        for (int i = 0; i < 50; i++) begin
            e = '{cyc: 739 + i, a: 2, b: 1 + i / 18, c: 1 + i % 18};
            q_win.push_back(e);
        end
        q_swap.push_back(406);
        q_swap.push_back(738);

        while (cyc < 789) begin
            bus_if.stall = (cyc >= 518) && (cyc <= 522);
            step();
            if (bus_if.stall) begin
                check("stall_win_en", 32'(s_win_en), 0);
                check("stall_row_hold", 32'(s_win_row), 7);
                check("stall_col_hold", 32'(s_win_col), 4);
            end
        end
        bus_if.stall = 1'b0;

        // Asynchronous reset mid-cycle during pass 2.
        #2;
        reset = 1'b0;
        step();
        check("arst_wr_en", 32'(s_wr_en), 0);
        check("arst_win_en", 32'(s_win_en), 0);
        check("arst_pass_id", 32'(s_pass_id), 0);
        check("arst_win_row", 32'(s_win_row), 0);
        check("arst_win_col", 32'(s_win_col), 0);
        check("arst_buf_swap", 32'(s_buf_swap), 0);
        check("arst_readable", 32'(s_readable), 0);
        check("arst_done", 32'(s_done), 0);
        check("arst_q_win", q_win.size(), 0);
        check("arst_q_swap", q_swap.size(), 0);
        check("arst_no_readable", n_rd, 0);

        // ---- Third frame: load restarts at group 0, early load_end at group 40 ----
        reset = 1'b1;
        cyc   = -1;
        for (int k = 0; k <= 40; k++) begin
            e = '{cyc: k, a: 0, b: k / 4, c: k % 4};
            q_wr.push_back(e);
        end
        for (int i = 0; i < 30; i++) begin
            e = '{cyc: 41 + i, a: 0, b: 1 + i / 18, c: 1 + i % 18};
            q_win.push_back(e);
        end
        while (cyc < 71) begin
            bus_if.load_end = (cyc == 40);
            step();
        end
        check("early_q_wr", q_wr.size(), 0);
        check("early_q_win", q_win.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
